// File: rtl/add64_arbiter.sv
// rtl/add64_arbiter.sv - two-requester arbiter sequencing one 16-bit CLA over four passes for 64-bit adds
//
// Purpose:
//   Grants one of two requesters (round-robin on ties), latches its operands
//   and carry-in, then drives a single cla16bit slice for four cycles, least
//   significant chunk first, chaining the carry through a register. The result
//   is presented with a one-cycle done/ack pulse.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req0, a0, b0, cin0   requester 0 request (held until ack0), operands, carry-in
//   req1, a1, b1, cin1   requester 1 request (held until ack1), operands, carry-in
//   ack0, ack1        one-cycle result-valid pulse per requester
//   done              one-cycle pulse, ack0 | ack1
//   gnt_id            requester currently or last served
//   busy              high while computing and during the done cycle
//   sum, cout         64-bit result and carry out of bit 63, valid while done

module add64_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [63:0] a0,
    input  logic [63:0] b0,
    input  logic        cin0,
    input  logic        req1,
    input  logic [63:0] a1,
    input  logic [63:0] b1,
    input  logic        cin1,
    output logic        ack0,
    output logic        ack1,
    output logic        done,
    output logic        gnt_id,
    output logic        busy,
    output logic [63:0] sum,
    output logic        cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic        prio_q, prio_d;     // requester favoured when both request
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic        gnt_q, gnt_d;
    logic [63:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        win;
    logic [5:0]  chunk_lsb;
    logic [15:0] add_a, add_b, add_s;
    logic        add_ci, add_co;

    // Contention goes to the favoured requester; otherwise whoever asks.
    assign win = (req0 && req1) ? prio_q : req1;

    assign chunk_lsb = {idx_q, 4'b0000};
    assign add_a     = a_q[chunk_lsb +: 16];
    assign add_b     = b_q[chunk_lsb +: 16];
    // First pass takes the requester's carry-in; later passes chain the slice carry.
    assign add_ci    = (idx_q == 2'd0) ? cin_q : carry_q;

    cla16bit u_cla (
        .a_i (add_a),
        .b_i (add_b),
        .c_i (add_ci),
        .s_o (add_s),
        .c_o (add_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        prio_d  = prio_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        gnt_d   = gnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = win;
                    prio_d  = ~win;
                    a_d     = win ? a1 : a0;
                    b_d     = win ? b1 : b0;
                    cin_d   = win ? cin1 : cin0;
                    idx_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                sum_d[chunk_lsb +: 16] = add_s;
                carry_d = add_co;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    cout_d  = add_co;
                    done_d  = 1'b1;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            prio_q  <= 1'b0;
            a_q     <= 64'd0;
            b_q     <= 64'd0;
            cin_q   <= 1'b0;
            gnt_q   <= 1'b0;
            sum_q   <= 64'd0;
            cout_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            prio_q  <= prio_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            gnt_q   <= gnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign done   = done_q;
    assign gnt_id = gnt_q;
    assign busy   = busy_q;
    assign sum    = sum_q;
    assign cout   = cout_q;

endmodule

// 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead level.
//   a_i, b_i  addends
//   c_i       carry in
//   s_o       sum
//   c_o       carry out of bit 15
module cla16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);

    logic [15:0] p, g, c;
    logic [3:0]  gp, gg;
    logic [4:0]  gc;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_grp
            localparam int B = 4 * k;
            assign gp[k] = &p[B+3:B];
            assign gg[k] = g[B+3]
                         | (p[B+3] & g[B+2])
                         | (p[B+3] & p[B+2] & g[B+1])
                         | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign c[B]   = gc[k];
            assign c[B+1] = g[B] | (p[B] & gc[k]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & gc[k]);
        end
    endgenerate

    // Group carries fully expanded so no group waits on the previous one.
    assign gc[0] = c_i;
    assign gc[1] = gg[0] | (gp[0] & c_i);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_i);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & c_i);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & c_i);

    assign s_o = p ^ c;
    assign c_o = gc[4];

endmodule

// File: tb/tb_add64_arbiter.sv
// tb/tb_add64_arbiter.sv - self-checking bench for add64_arbiter

module tb_add64_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, cin0, cin1;
    logic [63:0] a0, b0, a1, b1;
    logic        ack0, ack1, done, gnt_id, busy, cout;
    logic [63:0] sum;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    add64_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .cin0   (cin0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .cin1   (cin1),
        .ack0   (ack0),
        .ack1   (ack1),
        .done   (done),
        .gnt_id (gnt_id),
        .busy   (busy),
        .sum    (sum),
        .cout   (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an operation is the number of clock edges since its grant;
    // six edges from grant back to idle, result visible after the fifth.
    int          m_cnt;
    logic        m_gnt;
    logic        m_last;
    logic [63:0] m_sum;
    logic        m_cout;
    logic        chk_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic [64:0] full;
        logic        w;
        if (rst) begin
            m_cnt  = 0;
            m_gnt  = 1'b0;
            m_last = 1'b1;
        end else if (m_cnt == 0) begin
            if (req0 || req1) begin
                w      = (req0 && req1) ? ~m_last : req1;
                full   = w ? ({1'b0, a1} + {1'b0, b1} + {64'd0, cin1})
                           : ({1'b0, a0} + {1'b0, b0} + {64'd0, cin0});
                m_gnt  = w;
                m_last = w;
                m_sum  = full[63:0];
                m_cout = full[64];
                m_cnt  = 1;
            end
        end else if (m_cnt == 5) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {63'd0, busy}, {63'd0, m_cnt != 0});
            check("done", {63'd0, done}, {63'd0, m_cnt == 5});
            check("ack0", {63'd0, ack0}, {63'd0, (m_cnt == 5) && !m_gnt});
            check("ack1", {63'd0, ack1}, {63'd0, (m_cnt == 5) && m_gnt});
            check("gnt_id", {63'd0, gnt_id}, {63'd0, m_gnt});
            if (m_cnt == 5) begin
                check("model_sum", sum, m_sum);
                check("model_cout", {63'd0, cout}, {63'd0, m_cout});
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        if (!done) check("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic do_op(input string name, input logic who, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic [63:0] exp_sum, input logic exp_cout);
        int n;
        @(negedge clk);
        if (who) begin req1 = 1'b1; a1 = a; b1 = b; cin1 = ci; end
        else     begin req0 = 1'b1; a0 = a; b0 = b; cin0 = ci; end
        wait_done(n);
        check({name, "_latency"}, 64'(n), 64'd5);
        check({name, "_sum"}, sum, exp_sum);
        check({name, "_cout"}, {63'd0, cout}, {63'd0, exp_cout});
        check({name, "_gnt"}, {63'd0, gnt_id}, {63'd0, who});
        check({name, "_ack"}, {62'd0, ack1, ack0}, who ? 64'd2 : 64'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int last_cyc;
        logic who;
        req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        rst = 1'b1;
        #2;
        check("rst_sum", sum, 64'd0);
        check("rst_flags", {57'd0, cout, ack0, ack1, done, gnt_id, busy, 1'b0}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        do_op("single", 1'b0, 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 1'b0,
              64'h0000_0004_0000_0006, 1'b0);
        do_op("ripple", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1);
        do_op("chunk", 1'b1, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
              64'h0000_0000_0001_0000, 1'b0);

        // Fairness: both held high for four results.
        @(negedge clk);
        a0 = 64'd5; b0 = 64'd7; cin0 = 1'b0;
        a1 = 64'h8000_0000_0000_0000; b1 = 64'h8000_0000_0000_0000; cin1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        last_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            wait_done(n);
            who = ack1;
            check("fair_order", {63'd0, who}, 64'(i % 2));
            if (who) begin
                check("fair_sum1", sum, 64'd1);
                check("fair_cout1", {63'd0, cout}, 64'd1);
            end else begin
                check("fair_sum0", sum, 64'd12);
                check("fair_cout0", {63'd0, cout}, 64'd0);
            end
            if (i > 0) check("fair_spacing", 64'(cyc - last_cyc), 64'd6);
            last_cyc = cyc;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // Operand stability: inputs change and req drops one cycle after grant.
        @(negedge clk);
        a0 = 64'h1234_5678_9ABC_DEF0; b0 = 64'h1111_1111_1111_1111; cin0 = 1'b1;
        req0 = 1'b1;
        @(negedge clk);
        check("stab_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        a0 = 64'hDEAD_BEEF_0000_0000; b0 = 64'h0; cin0 = 1'b0; req0 = 1'b0;
        wait_done(n);
        check("stab_sum", sum, 64'h2345_6789_ABCD_F002);
        check("stab_ack0", {63'd0, ack0}, 64'd1);
        @(negedge clk);

        // Reset two edges into a computation.
        @(negedge clk);
        a1 = 64'd3; b1 = 64'd4; cin1 = 1'b0; req1 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_sum", sum, 64'd0);
        check("midrst_flags", {58'd0, cout, ack0, ack1, done, gnt_id, busy}, 64'd0);
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_op("after_rst", 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1,
              64'h0000_0001_0000_0001, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
